// File: rtl/conv_tap_delay.sv
// Strobed delay line with a runtime-selectable read tap over a circular buffer.
// The output returns the sample written `delay` strobes earlier.
module conv_tap_delay #(
  parameter int unsigned WIDTH              = 15,
  parameter int unsigned DEPTH_LOG2         = 4,
  parameter logic [WIDTH-1:0] INIT_STATE    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WIDTH-1:0]      in,
  input  logic [DEPTH_LOG2-1:0] delay,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] fill;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [WIDTH-1:0]      tap;

  // Tap address wraps naturally; delay=0 bypasses the RAM entirely.
  always_comb begin
    rd_addr = wr_ptr - delay;
    tap     = (delay == '0) ? in : mem[rd_addr];
  end

  // Buffer RAM is never reset; fill gating hides stale contents.
  always_ff @(posedge clk) begin
    if (en && !rst) begin
      mem[wr_ptr] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      fill      <= '0;
      out       <= INIT_STATE;
      out_valid <= 1'b0;
    end else if (en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (fill != '1) begin
        fill <= fill + 1'b1;
      end
      if (fill >= delay) begin
        out       <= tap;
        out_valid <= 1'b1;
      end else begin
        out       <= INIT_STATE;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_tap_delay.sv
// Directed bench for conv_tap_delay: fixed taps, wrap, sparse strobes,
// tap change mid-stream and reset colliding with a strobe.
module tb_conv_tap_delay;

  localparam int unsigned WIDTH      = 15;
  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned INIT_VAL   = 1;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic [WIDTH-1:0]      in;
  logic [DEPTH_LOG2-1:0] delay;
  logic [WIDTH-1:0]      out;
  logic                  out_valid;

  int unsigned n_checks;
  int unsigned n_pass;

  conv_tap_delay #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_STATE (15'(INIT_VAL))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (in),
    .delay     (delay),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input int e, input int din, input int d, input int r);
    @(negedge clk);
    en    = 1'(e);
    in    = 15'(din);
    delay = 4'(d);
    rst   = 1'(r);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int v, input int val);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_out"}, 32'(out), 32'(val));
  endtask

  task automatic do_reset(input string tag);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    expect_out(tag, 0, INIT_VAL);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; en = 1'b0; in = '0; delay = '0;

    // 1: D=3, continuous strobes
    do_reset("s1_rst");
    for (int s = 0; s < 24; s++) begin
      step(1, s, 3, 0);
      if (s < 3) expect_out("s1_fill", 0, INIT_VAL);
      else       expect_out("s1_run", 1, s - 3);
    end

    // 2: D=0 bypass
    do_reset("s2_rst");
    for (int s = 0; s < 10; s++) begin
      step(1, s, 0, 0);
      expect_out("s2_bypass", 1, s);
    end

    // 3: D=15 across two pointer wraps
    do_reset("s3_rst");
    for (int s = 0; s < 40; s++) begin
      step(1, s, 15, 0);
      if (s < 15) expect_out("s3_fill", 0, INIT_VAL);
      else        expect_out("s3_run", 1, s - 15);
    end

    // 4: D=2, one strobe every 4th clock; out must hold between strobes
    do_reset("s4_rst");
    for (int s = 0; s < 8; s++) begin
      int ev;
      int eo;
      ev = (s >= 2) ? 1 : 0;
      eo = (s >= 2) ? s - 2 : int'(INIT_VAL);
      step(1, s, 2, 0);
      expect_out("s4_strobe", ev, eo);
      for (int i = 0; i < 3; i++) begin
        step(0, 16'h7ff0 + i, 2, 0);
        expect_out("s4_hold", ev, eo);
      end
    end

    // 5: D=3 for 20 strobes, then switch to D=5
    do_reset("s5_rst");
    for (int s = 0; s < 20; s++) begin
      step(1, s, 3, 0);
    end
    expect_out("s5_pre", 1, 16);
    for (int s = 20; s < 26; s++) begin
      step(1, s, 5, 0);
      expect_out("s5_d5", 1, s - 5);
    end
    // Shrinking to D=0 after saturation switches straight to bypass
    step(1, 26, 0, 0);
    expect_out("s5_d0", 1, 26);

    // 6: reset collides with strobe 10
    do_reset("s6_rst");
    for (int s = 0; s < 10; s++) begin
      step(1, s, 3, 0);
    end
    expect_out("s6_pre", 1, 6);
    step(1, 10, 3, 1);
    expect_out("s6_rst_en", 0, INIT_VAL);
    for (int s = 0; s < 8; s++) begin
      step(1, 100 + s, 3, 0);
      if (s < 3) expect_out("s6_fill", 0, INIT_VAL);
      else       expect_out("s6_run", 1, 100 + s - 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
